// File: rtl/pa_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pa_pipe_pkg
//  Brief    : Shared pipeline widths, register-index/word types, REG_ZERO.
//  Revision : 1.0
// ============================================================================
package pa_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/pa_regfile_array.sv
`default_nettype none
// ============================================================================
//  Module   : pa_regfile_array
//  Brief    : NREGS x DATA_W register storage, 2 read / 1 write, r0 masked,
//             write-to-read bypass so a writeback is visible in the same cycle.
//  Revision : 1.0
// ============================================================================
module pa_regfile_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    import pa_pipe_pkg::REG_ZERO;

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Reads of r0 are forced to zero ahead of the bypass, so a wb to r0 never leaks.
    always_comb begin
        rdata_a = r_regs[raddr_a];
        if (raddr_a == REG_ZERO) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = r_regs[raddr_b];
        if (raddr_b == REG_ZERO) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pa_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : pa_rf_scoreboard
//  Brief    : Register file with busy-bit scoreboard; stalls RAW/WAW hazards,
//             registers operands to ID/EX, tracks pending writes.
//  Revision : 1.0
// ============================================================================
module pa_rf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_wen,
    output logic              op_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] op_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W:0]   pending_cnt,
    output logic              wb_err
);
    import pa_pipe_pkg::REG_ZERO;

    localparam logic [NREGS-1:0] c_one = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_wb_clr;
    logic [NREGS-1:0]  w_iss_set;
    logic [NREGS-1:0]  w_busy_eff;
    logic              w_wb_active;
    logic              w_accept;
    logic              w_set_en;
    logic              w_clr_busy;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    logic              r_op_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [ADDR_W-1:0] r_op_rd;
    logic [ADDR_W:0]   r_pending_cnt;
    logic              r_wb_err;

    pa_regfile_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_valid),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (issue_rs),
        .raddr_b (issue_rt),
        .rdata_a (w_rd_a),
        .rdata_b (w_rd_b)
    );

    assign w_wb_active = wb_valid && (wb_rd != REG_ZERO);
    assign w_wb_clr    = w_wb_active ? (c_one << wb_rd) : '0;
    assign w_busy_eff  = r_busy & ~w_wb_clr;

    assign issue_ready = ~w_busy_eff[issue_rs] & ~w_busy_eff[issue_rt]
                       & ~(issue_wen & w_busy_eff[issue_rd]);
    assign w_accept    = issue_valid & issue_ready;
    assign w_set_en    = w_accept & issue_wen & (issue_rd != REG_ZERO);
    assign w_iss_set   = w_set_en ? (c_one << issue_rd) : '0;
    assign w_clr_busy  = w_wb_active & r_busy[wb_rd];

    // Set is OR-ed after the clear so a same-cycle retire+reissue of rd stays busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_pending_cnt <= '0;
            r_wb_err      <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_wb_clr) | w_iss_set;
            case ({w_set_en, w_clr_busy})
                2'b10:   r_pending_cnt <= r_pending_cnt + (ADDR_W+1)'(1);
                2'b01:   r_pending_cnt <= r_pending_cnt - (ADDR_W+1)'(1);
                default: r_pending_cnt <= r_pending_cnt;
            endcase
            if (w_wb_active && !r_busy[wb_rd]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_op_rd    <= '0;
        end else begin
            r_op_valid <= w_accept;
            if (w_accept) begin
                r_rs_data <= w_rd_a;
                r_rt_data <= w_rd_b;
                r_op_rd   <= issue_rd;
            end
        end
    end

    assign op_valid    = r_op_valid;
    assign rs_data     = r_rs_data;
    assign rt_data     = r_rt_data;
    assign op_rd       = r_op_rd;
    assign pending_cnt = r_pending_cnt;
    assign wb_err      = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_pa_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pa_rf_scoreboard
//  Brief    : Directed self-checking bench with expected-operand queue.
//  Revision : 1.0
// ============================================================================
module tb_pa_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready, issue_wen;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        op_valid;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  op_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  pending_cnt;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_busy;
    int          mdl_cnt;
    logic        mdl_err;

    always #5 clk = ~clk;

    pa_rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs    (issue_rs),
        .issue_rt    (issue_rt),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .op_valid    (op_valid),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .op_rd       (op_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
        mdl_busy = '0;
        mdl_cnt  = 0;
        mdl_err  = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_op_valid"}, 64'(op_valid), 64'd0);
        chk({tag, "_rs_data"},  64'(rs_data),  64'd0);
        chk({tag, "_rt_data"},  64'(rt_data),  64'd0);
        chk({tag, "_op_rd"},    64'(op_rd),    64'd0);
        chk({tag, "_pending"},  64'(pending_cnt), 64'd0);
        chk({tag, "_wb_err"},   64'(wb_err),   64'd0);
    endtask

    // One clock: drive, check ready, push expectation, update model, check outputs.
    task automatic step(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic wen,
                        input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        logic [31:0] beff;
        logic        exp_rdy, acc;
        logic [31:0] rsv, rtv;
        exp_t        e;
        issue_valid = iv; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wen = wen;
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        #1;
        beff = mdl_busy;
        if (wv) beff[wrd] = 1'b0;
        exp_rdy = !beff[rs] && !beff[rt] && !(wen && beff[rd]);
        chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
        acc = iv && exp_rdy;
        if (acc) begin
            rsv = (rs == 0) ? 32'd0 : ((wv && wrd == rs) ? wd : mdl_regs[rs]);
            rtv = (rt == 0) ? 32'd0 : ((wv && wrd == rt) ? wd : mdl_regs[rt]);
            exp_q.push_back('{rs: rsv, rt: rtv, rd: rd});
        end
        if (wv && wrd != 0) begin
            if (!mdl_busy[wrd]) mdl_err = 1'b1;
            else mdl_cnt--;
            mdl_busy[wrd] = 1'b0;
            mdl_regs[wrd] = wd;
        end
        if (acc && wen && rd != 0) begin
            mdl_busy[rd] = 1'b1;
            mdl_cnt++;
        end
        @(posedge clk);
        #1;
        chk("op_valid", 64'(op_valid), 64'(acc));
        if (op_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_op", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rs_data", 64'(rs_data), 64'(e.rs));
                chk("rt_data", 64'(rt_data), 64'(e.rt));
                chk("op_rd",   64'(op_rd),   64'(e.rd));
            end
        end
        chk("pending_cnt", 64'(pending_cnt), 64'(mdl_cnt));
        chk("wb_err",      64'(wb_err),      64'(mdl_err));
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0; issue_wen = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_zero_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();

        // basic issue from reset: operands zero, r3 becomes pending
        step(1, 5'd1, 5'd2, 5'd3, 1, 0, 5'd0, 32'd0);
        chk("t1_rs_zero", 64'(rs_data), 64'd0);
        chk("t1_op_rd",   64'(op_rd),   64'd3);
        chk("t1_cnt",     64'(pending_cnt), 64'd1);

        // RAW stall on r3, then released by same-cycle writeback with bypass
        step(1, 5'd3, 5'd0, 5'd4, 0, 0, 5'd0, 32'd0);
        step(1, 5'd3, 5'd0, 5'd4, 0, 0, 5'd0, 32'd0);
        step(1, 5'd3, 5'd0, 5'd4, 0, 1, 5'd3, 32'hDEADBEEF);
        chk("t2_bypass", 64'(rs_data), 64'hDEADBEEF);
        chk("t2_cnt",    64'(pending_cnt), 64'd0);

        // WAW stall on r5, then retire+reissue in the same cycle
        step(1, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 32'd0);
        step(1, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 32'd0);
        step(1, 5'd0, 5'd0, 5'd5, 1, 1, 5'd5, 32'h0000_0055);
        chk("t3_cnt_same", 64'(pending_cnt), 64'd1);
        step(1, 5'd5, 5'd0, 5'd6, 0, 0, 5'd0, 32'd0);
        chk("t3_r5_busy_stall", 64'(op_valid), 64'd0);

        // r0 hardwired: write ignored, no error, never becomes pending
        step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 32'hFFFFFFFF);
        step(1, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0);
        chk("t4_r0_read", 64'(rs_data), 64'd0);
        chk("t4_r0_err",  64'(wb_err),  64'd0);
        step(1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 32'd0);
        chk("t4_r0_cnt",  64'(pending_cnt), 64'd1);

        // writeback to non-busy r7 still writes data and sets sticky error
        step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd7, 32'h0000_1234);
        chk("t5_err_set", 64'(wb_err), 64'd1);
        step(1, 5'd7, 5'd7, 5'd0, 0, 0, 5'd0, 32'd0);
        chk("t5_r7_data", 64'(rt_data), 64'h1234);
        chk("t5_err_sticky", 64'(wb_err), 64'd1);
        step(1, 5'd0, 5'd0, 5'd9, 1, 0, 5'd0, 32'd0);

        // asynchronous reset mid-cycle clears outputs at once
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // stale writeback for pre-reset issue of r9 is now an error
        step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd9, 32'h0000_0099);
        chk("t6_stale_err", 64'(wb_err), 64'd1);

        do_reset();

        // fill every writable register, then retire them all
        for (int i = 1; i < 32; i++) begin
            step(1, 5'd0, 5'd0, 5'(i), 1, 0, 5'd0, 32'd0);
        end
        chk("t7_cnt_full", 64'(pending_cnt), 64'd31);
        step(1, 5'd0, 5'd0, 5'd12, 1, 0, 5'd0, 32'd0);
        for (int i = 1; i < 32; i++) begin
            step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'(i), 32'(i * 3 + 32'h100));
        end
        chk("t7_cnt_empty", 64'(pending_cnt), 64'd0);
        chk("t7_err_clear", 64'(wb_err), 64'd0);
        step(1, 5'd17, 5'd31, 5'd0, 0, 0, 5'd0, 32'd0);
        chk("t7_r17", 64'(rs_data), 64'(17 * 3 + 32'h100));
        chk("t7_r31", 64'(rt_data), 64'(31 * 3 + 32'h100));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pa_rf_scoreboard.md
Name: pa_rf_scoreboard

Overview:
- Register file with a busy-bit scoreboard.
- Sits between the decode stage (read/issue side) and the writeback stage (write side).
- Decode issues an instruction only when its sources and destination are not pending; writeback retires results and clears the pending bits.
- Supplies registered operands to the ID/EX boundary, with same-cycle writeback bypass.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- NREGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  scoreboard accepts the instruction this cycle; combinational.
- issue_rs  in  ADDR_W  source register 1.
- issue_rt  in  ADDR_W  source register 2.
- issue_rd  in  ADDR_W  destination register.
- issue_wen  in  1  instruction will write rd.
- op_valid  out  1  operands registered this cycle are valid.
- rs_data  out  DATA_W  registered operand 1.
- rt_data  out  DATA_W  registered operand 2.
- op_rd  out  ADDR_W  registered destination, passed downstream.
- wb_valid  in  1  writeback presents a result.
- wb_rd  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- pending_cnt  out  ADDR_W+1  number of busy registers.
- wb_err  out  1  sticky: writeback hit a non-busy nonzero register.

Behaviour:
- Reset (async, rst_n low):
  - All registers and busy bits cleared.
  - op_valid, rs_data, rt_data, op_rd, pending_cnt and wb_err all 0.
  - issue_ready during reset is don't-care; the bench does not drive issue_valid while in reset.
- Register 0 is hardwired:
  - Reads return 0.
  - Writes are ignored.
  - It is never busy.
  - wb_rd==0 never sets wb_err.
- busy_eff[r] = busy[r] & ~(wb_valid & wb_rd==r). A same-cycle writeback clears the hazard.
- issue_ready = ~busy_eff[rs] & ~busy_eff[rt] & ~(issue_wen & busy_eff[rd]).
  - This stalls RAW hazards and also WAW hazards, so at most one write is outstanding per register.
- Accept = issue_valid & issue_ready. On the next posedge after accept:
  - op_valid=1 and op_rd=issue_rd.
  - rs_data and rt_data are read values; the bypass gives wb_data if wb_valid & wb_rd==source & source!=0.
  - If issue_wen & rd!=0, busy[rd] is set.
- With no accept, op_valid=0 on the next posedge; operand data holds its last value.
- Writeback with wb_valid & wb_rd!=0:
  - regs[wb_rd] <= wb_data and busy[wb_rd] is cleared.
  - If busy[wb_rd] was already 0, the data is still written and wb_err is set (sticky until reset).
- Simultaneous accept setting rd and a writeback clearing the same rd: the set wins. busy stays 1 and the new pending write is tracked.
- pending_cnt:
  - +1 on a set, -1 on a clear of a busy bit.
  - Net 0 when both happen on the same register.
  - Max value NREGS-1; it cannot overflow.
- Latency: issue to operands is 1 cycle; writeback to regfile visibility is 0 cycles via the bypass.
- Reset mid-operation: all pending state is discarded. Writebacks arriving after reset for pre-reset issues set wb_err.

Decomposition:
- Shared package pa_pipe_pkg holds:
  - DATA_W and ADDR_W.
  - REG_ZERO constant.
  - reg_idx_t and word_t typedefs.
- One sub-module, pa_regfile_array: NREGS x DATA_W storage with 2 read ports, 1 write port, reg-0 masking and write-to-read bypass.
- Scoreboard, issue_ready logic, counter and operand registers stay in pa_rf_scoreboard.

Test Plan:
- Reset, then issue rs=1 rt=2 rd=3 wen=1 -> issue_ready=1; next cycle op_valid=1, rs_data=0, rt_data=0, op_rd=3, pending_cnt=1.
- With r3 busy, issue rs=3 -> issue_ready=0 until writeback. Then wb rd=3 data=0xDEADBEEF in the same cycle as the issue -> ready=1 and rs_data=0xDEADBEEF next cycle.
- WAW: r5 pending, issue rd=5 wen=1 -> stalls. Same-cycle wb r5 plus issue rd=5 -> busy[5] stays 1 and pending_cnt is unchanged.
- wb rd=0 data=0xFFFFFFFF, then read r0 -> rs_data=0 and wb_err=0. Issue rd=0 wen=1 -> pending_cnt unchanged.
- wb rd=7 with r7 not busy -> regs[7] written and wb_err=1 stays high. Assert rst_n=0 mid-cycle -> all outputs 0 immediately.
- Issue 31 writes to r1..r31 back-to-back -> pending_cnt=31. Retire all 31 -> pending_cnt=0 and wb_err=0.
